// File: rtl/clock_boundary_stage.sv
// Fixed-latency retiming stage for one hring control-word lane.
// Wide data registers load only on valid flits; invalid slots leave the block as all-zero.
module clock_boundary_stage #(
  parameter int STAGES    = 1,  // latency in cycles, 1..8
  parameter int VALID_BIT = 0   // slot-valid bit within the flit, 0..143
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [143:0] port0_ci,
  output logic [143:0] port0_co
);

  typedef logic [143:0] control_w;

  // Handshake: none. The ring is bufferless, so one slot enters and one
  // leaves every cycle; port0_ci[VALID_BIT] alone qualifies the slot.

  logic     v_q [STAGES];
  control_w d_q [STAGES];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_head
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          v_q[0] <= 1'b0;
          d_q[0] <= '0;
        end else begin
          v_q[0] <= port0_ci[VALID_BIT];
          // Clock-enable on the wide register: idle slots keep the old word.
          if (port0_ci[VALID_BIT]) d_q[0] <= port0_ci;
        end
      end
    end else begin : g_link
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          v_q[i] <= 1'b0;
          d_q[i] <= '0;
        end else begin
          v_q[i] <= v_q[i-1];
          if (v_q[i-1]) d_q[i] <= d_q[i-1];
        end
      end
    end
  end

  // Stale data left behind in an idle slot must never leak onto the ring.
  assign port0_co = v_q[STAGES-1] ? d_q[STAGES-1] : '0;

endmodule

// File: tb/tb_clock_boundary_stage.sv
// Bench for clock_boundary_stage: STAGES=1 and STAGES=3 instances, directed
// vectors with hand-computed expected outputs checked by a scoreboard monitor.
module tb_clock_boundary_stage;

  localparam logic [143:0] PAT   = 144'h0123456789abcdef0123456789abcdef;
  localparam logic [143:0] FLT_A = 144'h11;
  localparam logic [143:0] FLT_B = 144'h23;
  localparam logic [143:0] FLT_C = 144'h35;
  localparam logic [143:0] FLT_D = 144'h77;

  logic         clk;
  logic         rst1, rst3;
  logic [143:0] ci1, ci3;
  logic [143:0] co1, co3;

  logic [143:0] exp1_q[$];
  logic [143:0] exp3_q[$];

  int n_vec;
  int n_err;

  clock_boundary_stage #(.STAGES(1), .VALID_BIT(0)) dut1 (
    .clk(clk), .rst(rst1), .port0_ci(ci1), .port0_co(co1)
  );

  clock_boundary_stage #(.STAGES(3), .VALID_BIT(0)) dut3 (
    .clk(clk), .rst(rst3), .port0_ci(ci3), .port0_co(co3)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Driver tasks: present a flit between edges and queue the output expected
  // just after the following rising edge.
  task automatic drive1(input logic [143:0] ci, input logic [143:0] exp_out);
    @(negedge clk);
    ci1 = ci;
    exp1_q.push_back(exp_out);
  endtask

  task automatic drive3(input logic [143:0] ci, input logic [143:0] exp_out);
    @(negedge clk);
    ci3 = ci;
    exp3_q.push_back(exp_out);
  endtask

  // Scoreboard monitor: one output slot per rising edge, sampled 1 time unit later.
  initial begin
    logic [143:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp1_q.size() > 0) begin
        e = exp1_q.pop_front();
        check("s1_out", co1, e);
      end
      if (exp3_q.size() > 0) begin
        e = exp3_q.pop_front();
        check("s3_out", co3, e);
      end
    end
  end

  initial begin
    logic [143:0] rnd;
    n_vec = 0;
    n_err = 0;
    rst1 = 1'b0;
    rst3 = 1'b0;
    ci1  = '0;
    ci3  = '0;

    // Reset hold: valid input present, output stays zero across two edges.
    drive1(PAT, 144'h0);
    drive1(PAT, 144'h0);
    @(posedge clk);
    #2;
    check("reset_hold_s3", co3, 144'h0);
    rst1 = 1'b1;
    rst3 = 1'b1;

    // Valid pass-through, then the same value again.
    drive1(PAT, PAT);
    drive1(PAT, PAT);

    // Invalid masking, then the minimal valid flit.
    drive1({{143{1'b1}}, 1'b0}, 144'h0);
    drive1(144'h1, 144'h1);

    // Data-hold: valid 5 followed by ten invalid flits with random upper bits.
    drive1(144'h5, 144'h5);
    for (int k = 0; k < 10; k++) begin
      for (int w = 0; w < 5; w++) rnd = {rnd[111:0], 32'($urandom)};
      rnd[0] = 1'b0;
      drive1(rnd, 144'h0);
      @(posedge clk);
      #2;
      check("d0_hold", dut1.d_q[0], 144'h5);
    end
    drive1(144'h0, 144'h0);

    // Latency for STAGES=3: A,B,C on consecutive edges emerge at edges 3,4,5.
    drive3(FLT_A, 144'h0);
    drive3(FLT_B, 144'h0);
    drive3(FLT_C, FLT_A);
    drive3(144'h0, FLT_B);
    drive3(144'h0, FLT_C);
    drive3(144'h0, 144'h0);
    drive3(144'h0, 144'h0);

    // Asynchronous reset mid-stream: A at the output, B and C in flight.
    drive3(FLT_A, 144'h0);
    drive3(FLT_B, 144'h0);
    drive3(FLT_C, FLT_A);
    @(posedge clk);
    #3;
    check("pre_reset_a", co3, FLT_A);
    ci3  = '0;
    rst3 = 1'b0;
    #1;
    check("async_reset", co3, 144'h0);
    #2;
    rst3 = 1'b1;

    // B and C must not reappear; a new flit D emerges with normal latency.
    drive3(144'h0, 144'h0);
    drive3(144'h0, 144'h0);
    drive3(FLT_D, 144'h0);
    drive3(144'h0, 144'h0);
    drive3(144'h0, FLT_D);
    drive3(144'h0, 144'h0);

    // Drain the scoreboard with a bounded wait.
    for (int t = 0; t < 20 && (exp1_q.size() > 0 || exp3_q.size() > 0); t++)
      @(posedge clk);
    #3;
    n_vec++;
    if (exp1_q.size() > 0 || exp3_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", exp1_q.size() + exp3_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
